// File: rtl/seg7_id_capture.sv
// Receive-side monitor for an active-low seven-segment digit stream: waits for each
// pattern to settle, decodes it back to BCD and collects digits for comparison to an expected ID.
module seg7_id_capture #(
  parameter int                 STABLE_CYCLES = 16,
  parameter int                 DEPTH         = 8,
  parameter logic [4*DEPTH-1:0] EXPECTED      = '0
) (
  input  logic                       clk_50M,
  input  logic                       reset,
  input  logic [6:0]                 seg_in,
  input  logic                       clear,
  output logic [3:0]                 digit_out,
  output logic                       digit_valid,
  output logic [4*DEPTH-1:0]         id_digits,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       match,
  output logic                       err
);

  localparam int SW    = $clog2(STABLE_CYCLES);
  localparam int CW    = $clog2(DEPTH+1);
  localparam logic [SW-1:0] ACCEPT_AT = SW'(STABLE_CYCLES - 2);
  localparam logic [SW-1:0] SAT_AT    = SW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [6:0]    SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    K_DIGIT = 2'd0,
    K_BLANK = 2'd1,
    K_BAD   = 2'd2
  } kind_t;

  logic [6:0]    seg_q;
  logic [SW-1:0] stable_cnt;
  logic          armed;
  logic          accept;
  kind_t         kind;
  logic [3:0]    dec_digit;

  // Accept fires on the STABLE_CYCLES-th identical sample; armed limits it to once per pattern.
  assign accept = armed && (stable_cnt == ACCEPT_AT) && (seg_in == seg_q);
  assign full   = (count == DEPTH_C);

  always_comb begin
    kind      = K_DIGIT;
    dec_digit = 4'd0;
    case (seg_q)
      7'b1000000: dec_digit = 4'd0;
      7'b1111001: dec_digit = 4'd1;
      7'b0100100: dec_digit = 4'd2;
      7'b0110000: dec_digit = 4'd3;
      7'b0011001: dec_digit = 4'd4;
      7'b0010010: dec_digit = 4'd5;
      7'b0000010: dec_digit = 4'd6;
      7'b1111000,
      7'b1011000: dec_digit = 4'd7;
      7'b0000000: dec_digit = 4'd8;
      7'b0010000,
      7'b0011000: dec_digit = 4'd9;
      SEG_BLANK:  kind      = K_BLANK;
      default:    kind      = K_BAD;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      seg_q      <= SEG_BLANK;
      stable_cnt <= '0;
      armed      <= 1'b1;
    end else begin
      seg_q <= seg_in;
      if (seg_in != seg_q) begin
        stable_cnt <= '0;
        armed      <= 1'b1;
      end else begin
        if (stable_cnt != SAT_AT) stable_cnt <= stable_cnt + 1'b1;
        if (accept) armed <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      digit_out   <= 4'd0;
      digit_valid <= 1'b0;
      id_digits   <= '0;
      count       <= '0;
      match       <= 1'b0;
      err         <= 1'b0;
    end else begin
      digit_valid <= 1'b0;
      // match trails the buffer by one cycle since it is computed from registered state.
      match       <= full && (id_digits == EXPECTED);
      if (clear) begin
        id_digits <= '0;
        count     <= '0;
        match     <= 1'b0;
        err       <= 1'b0;
      end else if (accept) begin
        case (kind)
          K_DIGIT: begin
            digit_out   <= dec_digit;
            digit_valid <= 1'b1;
            if (!full) begin
              id_digits <= {id_digits[4*DEPTH-5:0], dec_digit};
              count     <= count + 1'b1;
            end
          end
          K_BAD:   err <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_id_capture.sv
// Directed bench for seg7_id_capture with STABLE_CYCLES=4, DEPTH=4, EXPECTED=16'h1234.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seg7_id_capture;

  localparam logic [6:0] P0  = 7'b1000000;
  localparam logic [6:0] P1  = 7'b1111001;
  localparam logic [6:0] P2  = 7'b0100100;
  localparam logic [6:0] P3  = 7'b0110000;
  localparam logic [6:0] P4  = 7'b0011001;
  localparam logic [6:0] P5  = 7'b0010010;
  localparam logic [6:0] P6  = 7'b0000010;
  localparam logic [6:0] P7  = 7'b1111000;
  localparam logic [6:0] P7B = 7'b1011000;
  localparam logic [6:0] P8  = 7'b0000000;
  localparam logic [6:0] P9  = 7'b0010000;
  localparam logic [6:0] P9B = 7'b0011000;
  localparam logic [6:0] BLK = 7'b1111111;
  localparam logic [6:0] PE  = 7'b0000110;

  logic        clk_50M;
  logic        reset;
  logic [6:0]  seg_in;
  logic        clear;
  logic [3:0]  digit_out;
  logic        digit_valid;
  logic [15:0] id_digits;
  logic [2:0]  count;
  logic        full;
  logic        match;
  logic        err;

  int vectors;
  int miscompares;
  int pulses;
  int first;
  int total;

  seg7_id_capture #(
    .STABLE_CYCLES(4),
    .DEPTH        (4),
    .EXPECTED     (16'h1234)
  ) dut (
    .clk_50M    (clk_50M),
    .reset      (reset),
    .seg_in     (seg_in),
    .clear      (clear),
    .digit_out  (digit_out),
    .digit_valid(digit_valid),
    .id_digits  (id_digits),
    .count      (count),
    .full       (full),
    .match      (match),
    .err        (err)
  );

  initial clk_50M = 1'b0;
  always #5 clk_50M = ~clk_50M;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive pattern p for n falling edges; report pulse count and the edge index of the first pulse.
  task automatic hold(input logic [6:0] p, input int n, output int np, output int fi);
    seg_in = p;
    np = 0;
    fi = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk_50M);
      if (digit_valid === 1'b1) begin
        np++;
        if (fi == 0) fi = i;
      end
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk_50M);
    clear = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_digit_out"}, 32'(digit_out), 32'h0);
    chk({tag, "_valid"},     32'(digit_valid), 32'h0);
    chk({tag, "_id"},        32'(id_digits), 32'h0);
    chk({tag, "_count"},     32'(count), 32'h0);
    chk({tag, "_full"},      32'(full), 32'h0);
    chk({tag, "_match"},     32'(match), 32'h0);
    chk({tag, "_err"},       32'(err), 32'h0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset  = 1'b1;
    clear  = 1'b0;
    seg_in = BLK;
    repeat (3) @(negedge clk_50M);
    reset = 1'b0;

    // 1: reset state, single digit latency
    chk_reset_state("rst");
    hold(P1, 10, pulses, first);
    chk("t1_pulses", 32'(pulses), 32'd1);
    chk("t1_latency", 32'(first), 32'd4);
    chk("t1_digit", 32'(digit_out), 32'd1);
    chk("t1_id", 32'(id_digits), 32'h0001);
    chk("t1_count", 32'(count), 32'd1);

    // 2: fill buffer with 1,2,3,4, check match, then overflow with 5
    hold(BLK, 2, pulses, first);
    do_clear();
    chk("t2_clr_count", 32'(count), 32'd0);
    total = 0;
    hold(P1, 6, pulses, first); total += pulses;
    hold(BLK, 2, pulses, first);
    hold(P2, 6, pulses, first); total += pulses;
    hold(BLK, 2, pulses, first);
    hold(P3, 6, pulses, first); total += pulses;
    hold(BLK, 2, pulses, first);
    hold(P4, 4, pulses, first); total += pulses;
    chk("t2_pulses", 32'(total), 32'd4);
    chk("t2_id", 32'(id_digits), 32'h1234);
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_match_early", 32'(match), 32'd0);
    hold(P4, 1, pulses, first);
    chk("t2_match", 32'(match), 32'd1);
    hold(P4, 1, pulses, first);
    hold(BLK, 2, pulses, first);
    hold(P5, 6, pulses, first);
    chk("t2_ovf_pulse", 32'(pulses), 32'd1);
    chk("t2_ovf_digit", 32'(digit_out), 32'd5);
    chk("t2_ovf_id", 32'(id_digits), 32'h1234);
    chk("t2_ovf_count", 32'(count), 32'd4);
    chk("t2_ovf_match", 32'(match), 32'd1);

    // 3: repeated 7 via blank separator, long hold, alternate 9 encoding
    hold(BLK, 2, pulses, first);
    do_clear();
    chk("t3_clr_match", 32'(match), 32'd0);
    hold(P7, 6, pulses, first);
    hold(BLK, 2, pulses, first);
    hold(P7B, 6, pulses, first);
    chk("t3_id77", 32'(id_digits), 32'h0077);
    chk("t3_count2", 32'(count), 32'd2);
    hold(BLK, 2, pulses, first);
    hold(P7, 20, pulses, first);
    chk("t3_long_pulses", 32'(pulses), 32'd1);
    chk("t3_id777", 32'(id_digits), 32'h0777);
    hold(BLK, 2, pulses, first);
    hold(P9B, 6, pulses, first);
    chk("t3_id7779", 32'(id_digits), 32'h7779);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_nomatch", 32'(match), 32'd0);

    // 4: invalid pattern sets sticky err; clear resets it
    hold(BLK, 2, pulses, first);
    do_clear();
    hold(P6, 6, pulses, first);
    chk("t4_id6", 32'(id_digits), 32'h0006);
    hold(BLK, 2, pulses, first);
    hold(PE, 5, pulses, first);
    chk("t4_err_pulses", 32'(pulses), 32'd0);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_err_count", 32'(count), 32'd1);
    hold(BLK, 4, pulses, first);
    chk("t4_err_sticky", 32'(err), 32'd1);
    do_clear();
    chk("t4_clr_err", 32'(err), 32'd0);
    chk("t4_clr_count", 32'(count), 32'd0);
    chk("t4_clr_id", 32'(id_digits), 32'h0);
    hold(P8, 6, pulses, first);
    hold(BLK, 2, pulses, first);
    hold(P0, 6, pulses, first);
    chk("t4_id80", 32'(id_digits), 32'h0080);
    chk("t4_digit0", 32'(digit_out), 32'd0);

    // 5: short glitch of 2 is rejected, 3 accepted
    hold(BLK, 2, pulses, first);
    hold(P2, 3, pulses, first);
    total = pulses;
    hold(P3, 5, pulses, first);
    total += pulses;
    chk("t5_pulses", 32'(total), 32'd1);
    chk("t5_id", 32'(id_digits), 32'h0803);
    chk("t5_digit", 32'(digit_out), 32'd3);

    // 6: reset mid-settle, then re-evaluation of held pattern
    hold(BLK, 2, pulses, first);
    hold(P9, 2, pulses, first);
    reset = 1'b1;
    @(negedge clk_50M);
    chk_reset_state("t6_rst");
    reset = 1'b0;
    hold(P9, 6, pulses, first);
    chk("t6_reeval_pulses", 32'(pulses), 32'd1);
    chk("t6_reeval_latency", 32'(first), 32'd4);
    chk("t6_reeval_id", 32'(id_digits), 32'h0009);

    // 6b: clear coinciding with an accept wins
    hold(BLK, 2, pulses, first);
    hold(P4, 3, pulses, first);
    clear = 1'b1;
    @(negedge clk_50M);
    clear = 1'b0;
    chk("t6_clr_valid", 32'(digit_valid), 32'd0);
    chk("t6_clr_count", 32'(count), 32'd0);
    chk("t6_clr_id", 32'(id_digits), 32'h0);
    chk("t6_clr_digit_held", 32'(digit_out), 32'd9);
    hold(P4, 6, pulses, first);
    chk("t6_no_reaccept", 32'(pulses), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
